// File: rtl/axi2apb_xfer_ctrl.sv
// AXI-Lite to APB transfer controller: read/write arbitration, built-in slot decode,
// one APB SETUP/ACCESS sequence at a time with bounded wait, then B or R response.
module axi2apb_xfer_ctrl #(
  parameter logic [3:0]  SLV_MAP = 4'b0010,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [3:0]  PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [15:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;
  typedef enum logic {GNT_WRITE, GNT_READ} gnt_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e      state_q;
  gnt_e        last_q;
  logic [7:0]  cnt_q;
  logic        awready_q;
  logic        arready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;
  logic [3:0]  psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [15:0] paddr_q;
  logic [31:0] pwdata_q;

  logic        wr_req;
  logic        rd_req;
  logic        gnt_rd_d;
  logic        gnt_wr_d;
  logic [31:0] gnt_addr;
  logic [3:0]  psel_d;
  logic        hit_d;
  logic [7:0]  cnt_d;

  assign wr_req   = AWVALID && WVALID;
  assign rd_req   = ARVALID;
  assign gnt_rd_d = rd_req && (!wr_req || (last_q == GNT_WRITE));
  assign gnt_wr_d = wr_req && (!rd_req || (last_q == GNT_READ));
  assign gnt_addr = arready_q ? ARADDR : AWADDR;
  assign cnt_d    = cnt_q + 8'd1;

  always_comb begin
    psel_d = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      if (SLV_MAP[n[1:0]] && (gnt_addr[31:16] == (16'hA000 + 16'(n))))
        psel_d[n[1:0]] = 1'b1;
    end
    hit_d = |psel_d;
  end

  // READY is raised one cycle after the request is seen; the edge that closes
  // that READY cycle is the handshake, where address/data are latched and decoded.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      last_q    <= GNT_WRITE;
      cnt_q     <= '0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (awready_q || arready_q) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            pwrite_q  <= awready_q;
            paddr_q   <= gnt_addr[15:0];
            if (awready_q) pwdata_q <= WDATA;
            if (hit_d) begin
              psel_q  <= psel_d;
              state_q <= S_SETUP;
            end else begin
              if (awready_q) begin
                bvalid_q <= 1'b1;
                bresp_q  <= RESP_SLVERR;
              end else begin
                rvalid_q <= 1'b1;
                rresp_q  <= RESP_SLVERR;
                rdata_q  <= '0;
              end
              state_q <= S_RESP;
            end
          end else if (gnt_rd_d) begin
            arready_q <= 1'b1;
            last_q    <= GNT_READ;
          end else if (gnt_wr_d) begin
            awready_q <= 1'b1;
            last_q    <= GNT_WRITE;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (PREADY) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            if (pwrite_q) begin
              bvalid_q <= 1'b1;
              bresp_q  <= PSLVERR ? RESP_SLVERR : RESP_OKAY;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= PSLVERR ? RESP_SLVERR : RESP_OKAY;
              rdata_q  <= PRDATA;
            end
            state_q <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            if (pwrite_q) begin
              bvalid_q <= 1'b1;
              bresp_q  <= RESP_SLVERR;
            end else begin
              rvalid_q <= 1'b1;
              rresp_q  <= RESP_SLVERR;
              rdata_q  <= '0;
            end
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          if ((bvalid_q && BREADY) || (rvalid_q && RREADY)) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = awready_q;
  assign ARREADY = arready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_axi2apb_xfer_ctrl.sv
// Directed self-checking bench for axi2apb_xfer_ctrl (default slot map, TIMEOUT = 16).
module tb_axi2apb_xfer_ctrl;

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int errors = 0;
  int checks = 0;

  axi2apb_xfer_ctrl #(.SLV_MAP(4'b0010), .TIMEOUT(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic test_reset;
    logic [124:0] outs;
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0; PRDATA = '0; PREADY = 0; PSLVERR = 0;
    repeat (2) @(negedge ACLK);
    outs = {AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP, RDATA,
            PSEL, PENABLE, PWRITE, PADDR, PWDATA};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if ({AWREADY, ARREADY, PSEL} !== 6'b0) begin
      errors++; $display("FAIL reset_idle: got %b expected 0", {AWREADY, ARREADY, PSEL});
    end
  endtask

  task automatic test_read_hit;
    @(negedge ACLK);
    ARADDR = 32'hA001_0010; ARVALID = 1; PREADY = 1; PSLVERR = 0;
    PRDATA = 32'h1234_5678; RREADY = 0;
    @(negedge ACLK); // N
    checks++;
    if ({ARREADY, AWREADY, PSEL} !== 6'b100000) begin
      errors++; $display("FAIL rd_grant: got %b expected 100000", {ARREADY, AWREADY, PSEL});
    end
    @(negedge ACLK); // N+1
    ARVALID = 0;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, ARREADY} !== {4'b0010, 1'b0, 1'b0, 16'h0010, 1'b0}) begin
      errors++; $display("FAIL rd_setup: got psel=%b en=%b wr=%b addr=%h expected 0010 0 0 0010",
                         PSEL, PENABLE, PWRITE, PADDR);
    end
    @(negedge ACLK); // N+2
    checks++;
    if ({PSEL, PENABLE, RVALID} !== 6'b001010) begin
      errors++; $display("FAIL rd_access: got %b expected 001010", {PSEL, PENABLE, RVALID});
    end
    @(negedge ACLK); // N+3
    checks++;
    if ({RVALID, RRESP, RDATA, PSEL, PENABLE} !== {1'b1, 2'b00, 32'h1234_5678, 4'b0, 1'b0}) begin
      errors++; $display("FAIL rd_resp: got v=%b resp=%b data=%h psel=%b en=%b expected 1 00 12345678 0000 0",
                         RVALID, RRESP, RDATA, PSEL, PENABLE);
    end
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
    checks++;
    if (RVALID !== 1'b0) begin
      errors++; $display("FAIL rd_done: got rvalid=%b expected 0", RVALID);
    end
  endtask

  task automatic test_write_wait;
    int bad;
    @(negedge ACLK);
    AWADDR = 32'hA001_0004; WDATA = 32'hDEAD_BEEF; AWVALID = 1; WVALID = 1;
    PREADY = 0; PSLVERR = 0; BREADY = 0;
    @(negedge ACLK); // N
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b110) begin
      errors++; $display("FAIL wr_grant: got %b expected 110", {AWREADY, WREADY, ARREADY});
    end
    @(negedge ACLK); // N+1
    AWVALID = 0; WVALID = 0;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {4'b0010, 1'b0, 1'b1, 16'h0004, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL wr_setup: got psel=%b en=%b wr=%b addr=%h data=%h expected 0010 0 1 0004 deadbeef",
                         PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin // N+2..N+5, PREADY low for the first three
      @(negedge ACLK);
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, BVALID} !==
          {4'b0010, 1'b1, 1'b1, 16'h0004, 32'hDEAD_BEEF, 1'b0}) bad++;
    end
    PREADY = 1;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL wr_hold: got %0d bad access cycles expected 0", bad);
    end
    @(negedge ACLK); // N+6
    PREADY = 0;
    checks++;
    if ({BVALID, BRESP, PSEL, PENABLE} !== {1'b1, 2'b00, 4'b0, 1'b0}) begin
      errors++; $display("FAIL wr_resp: got v=%b resp=%b psel=%b en=%b expected 1 00 0000 0",
                         BVALID, BRESP, PSEL, PENABLE);
    end
    @(negedge ACLK); // N+7, BREADY still low
    checks++;
    if ({BVALID, BRESP} !== 3'b100) begin
      errors++; $display("FAIL wr_bhold: got %b expected 100", {BVALID, BRESP});
    end
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    checks++;
    if (BVALID !== 1'b0) begin
      errors++; $display("FAIL wr_done: got bvalid=%b expected 0", BVALID);
    end
  endtask

  task automatic test_unmapped;
    @(negedge ACLK);
    ARADDR = 32'hA002_0000; ARVALID = 1; RREADY = 0; PREADY = 1; PRDATA = 32'h5555_AAAA;
    @(negedge ACLK); // N
    checks++;
    if ({ARREADY, PSEL} !== 5'b10000) begin
      errors++; $display("FAIL um_grant: got %b expected 10000", {ARREADY, PSEL});
    end
    @(negedge ACLK); // N+1
    ARVALID = 0;
    checks++;
    if ({RVALID, RRESP, RDATA, PSEL, PENABLE} !== {1'b1, 2'b10, 32'h0, 4'b0, 1'b0}) begin
      errors++; $display("FAIL um_resp: got v=%b resp=%b data=%h psel=%b en=%b expected 1 10 00000000 0000 0",
                         RVALID, RRESP, RDATA, PSEL, PENABLE);
    end
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0; PREADY = 0;
    checks++;
    if ({RVALID, PSEL} !== 5'b0) begin
      errors++; $display("FAIL um_done: got %b expected 00000", {RVALID, PSEL});
    end
  endtask

  task automatic test_arbitration;
    logic [5:0] exp_rd;
    int unsigned idx, rcnt, bcnt;
    logic drop_ar, drop_aw;
    exp_rd = 6'b010101; // bit i = 1 means grant i must be a read
    idx = 0; rcnt = 0; bcnt = 0; drop_ar = 0; drop_aw = 0;
    ARESETn = 0;
    @(negedge ACLK);
    ARESETn = 1;
    AWADDR = 32'hA001_0100; ARADDR = 32'hA001_0200; WDATA = 32'h0F0F_0F0F;
    PRDATA = 32'h0000_0042; PREADY = 1; PSLVERR = 0; RREADY = 1; BREADY = 1;
    ARVALID = 1; AWVALID = 1; WVALID = 1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge ACLK);
      if (drop_ar) begin ARVALID = 0; drop_ar = 0; end
      if (drop_aw) begin AWVALID = 0; WVALID = 0; drop_aw = 0; end
      if (RVALID) rcnt++;
      if (BVALID) bcnt++;
      if (ARREADY || AWREADY) begin
        checks++;
        if (idx >= 6) begin
          errors++; $display("FAIL arb_extra: got grant %0d expected none", idx);
        end else if ({ARREADY, AWREADY, WREADY} !== {exp_rd[idx], !exp_rd[idx], !exp_rd[idx]}) begin
          errors++; $display("FAIL arb_order: grant %0d got ar/aw/w=%b expected %b", idx,
                             {ARREADY, AWREADY, WREADY}, {exp_rd[idx], !exp_rd[idx], !exp_rd[idx]});
        end
        drop_ar = ARREADY; drop_aw = AWREADY;
        idx++;
      end
      if (!ARVALID && !AWVALID && idx < 6) begin
        ARVALID = 1; AWVALID = 1; WVALID = 1;
      end
    end
    RREADY = 0; BREADY = 0; PREADY = 0;
    checks++;
    if ({idx, rcnt, bcnt} !== {32'd6, 32'd3, 32'd3}) begin
      errors++; $display("FAIL arb_count: got grants=%0d r=%0d b=%0d expected 6 3 3", idx, rcnt, bcnt);
    end
  endtask

  task automatic test_timeout;
    int bad;
    @(negedge ACLK);
    AWADDR = 32'hA001_0008; WDATA = 32'h1111_2222; AWVALID = 1; WVALID = 1;
    PREADY = 0; PSLVERR = 0; BREADY = 0;
    @(negedge ACLK); // N
    @(negedge ACLK); // N+1
    AWVALID = 0; WVALID = 0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin // N+2..N+17
      @(negedge ACLK);
      if ({PSEL, PENABLE, BVALID} !== 6'b001010) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL to_wait: got %0d bad access cycles expected 0", bad);
    end
    @(negedge ACLK); // N+18
    checks++;
    if ({PSEL, PENABLE, BVALID, BRESP} !== {4'b0, 1'b0, 1'b1, 2'b10}) begin
      errors++; $display("FAIL to_resp: got psel=%b en=%b v=%b resp=%b expected 0000 0 1 10",
                         PSEL, PENABLE, BVALID, BRESP);
    end
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;

    // PREADY arriving on the 16th ACCESS cycle is a normal completion
    AWADDR = 32'hA001_000C; AWVALID = 1; WVALID = 1;
    @(negedge ACLK); // N
    @(negedge ACLK); // N+1
    AWVALID = 0; WVALID = 0;
    repeat (15) @(negedge ACLK); // N+2..N+16
    @(negedge ACLK); // N+17
    checks++;
    if ({PENABLE, BVALID} !== 2'b10) begin
      errors++; $display("FAIL to_edge_wait: got en/v=%b expected 10", {PENABLE, BVALID});
    end
    PREADY = 1;
    @(negedge ACLK); // N+18
    PREADY = 0;
    checks++;
    if ({BVALID, BRESP} !== 3'b100) begin
      errors++; $display("FAIL to_edge_resp: got %b expected 100", {BVALID, BRESP});
    end
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;

    ARADDR = 32'hA001_0020; ARVALID = 1; PREADY = 1; PSLVERR = 1;
    PRDATA = 32'hCAFE_F00D; RREADY = 0;
    @(negedge ACLK); // N
    @(negedge ACLK); // N+1
    ARVALID = 0;
    @(negedge ACLK); // N+2
    @(negedge ACLK); // N+3
    checks++;
    if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b10, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL slverr_resp: got v=%b resp=%b data=%h expected 1 10 cafef00d",
                         RVALID, RRESP, RDATA);
    end
    RREADY = 1; PSLVERR = 0;
    @(negedge ACLK);
    RREADY = 0; PREADY = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge ACLK);
    ARADDR = 32'hA001_0030; ARVALID = 1; PREADY = 0; RREADY = 0;
    @(negedge ACLK); // N
    @(negedge ACLK); // N+1
    ARVALID = 0;
    @(negedge ACLK); // N+2
    checks++;
    if ({PSEL, PENABLE} !== 5'b00101) begin
      errors++; $display("FAIL rm_access: got %b expected 00101", {PSEL, PENABLE});
    end
    #2 ARESETn = 0;
    #1;
    checks++;
    if ({PSEL, PENABLE, RVALID, BVALID, RDATA} !== '0) begin
      errors++; $display("FAIL rm_abort: got psel=%b en=%b rv=%b bv=%b data=%h expected all 0",
                         PSEL, PENABLE, RVALID, BVALID, RDATA);
    end
    @(negedge ACLK);
    ARESETn = 1;
    ARADDR = 32'hA001_0040; ARVALID = 1; PREADY = 1; PRDATA = 32'h0BAD_F00D;
    @(negedge ACLK); // N
    checks++;
    if (ARREADY !== 1'b1) begin
      errors++; $display("FAIL rm_regrant: got arready=%b expected 1", ARREADY);
    end
    @(negedge ACLK); // N+1
    ARVALID = 0;
    @(negedge ACLK); // N+2
    @(negedge ACLK); // N+3
    checks++;
    if ({RVALID, RRESP, RDATA} !== {1'b1, 2'b00, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL rm_fresh: got v=%b resp=%b data=%h expected 1 00 0badf00d",
                         RVALID, RRESP, RDATA);
    end
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_wait();
    test_unmapped();
    test_arbitration();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
